// File: rtl/if_fetch_align.sv
// RV32IC instruction-fetch aligner: holds the fetch PC, reads whole words and
// carves out 16/32-bit instructions, using a one-halfword stash for straddlers.
module if_fetch_align #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENA,
  input  logic        PC_SEL,
  input  logic [31:0] PC_TARGET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] OUT_INSTRUCTION,
  output logic [31:0] OUT_PC,
  output logic        OUT_COMPRESS,
  output logic        OUT_ILLEGAL,
  output logic        OUT_BUBBLE
);

  // Encoding is {half_valid, pc[1]}; 2'b10 is unreachable while the invariant holds.
  typedef enum logic [1:0] {
    ALIGNED    = 2'b00,
    MISALIGNED = 2'b01,
    INVALID    = 2'b10,
    BUFFERED   = 2'b11
  } fetch_state_e;

  logic [31:0]  pc_q, pc_d;
  logic [15:0]  half_buf_q, half_buf_d;
  logic         half_valid_q, half_valid_d;
  logic [31:0]  adv_pc;
  logic [15:0]  adv_buf;
  logic         adv_valid;
  logic [31:0]  word_addr;
  fetch_state_e state;

  assign state     = fetch_state_e'({half_valid_q, pc_q[1]});
  assign word_addr = {pc_q[31:2], 2'b00};

  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

  // Emission and the "advance" next-state, both purely from state and IMEM_RDATA.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    adv_pc          = pc_q;
    adv_buf         = half_buf_q;
    adv_valid       = half_valid_q;
    OUT_INSTRUCTION = NOP_INSTR;
    OUT_PC          = pc_q;
    OUT_COMPRESS    = 1'b0;
    OUT_BUBBLE      = 1'b0;
    IMEM_ADDR       = half_valid_q ? word_addr + 32'd4 : word_addr;

    case (state)
      ALIGNED: begin
        if (is_rvc(IMEM_RDATA[15:0])) begin
          OUT_INSTRUCTION = {16'h0000, IMEM_RDATA[15:0]};
          OUT_COMPRESS    = 1'b1;
          adv_pc          = pc_q + 32'd2;
          adv_buf         = IMEM_RDATA[31:16];
          adv_valid       = 1'b1;
        end else begin
          OUT_INSTRUCTION = IMEM_RDATA;
          adv_pc          = pc_q + 32'd4;
        end
      end
      BUFFERED: begin
        if (is_rvc(half_buf_q)) begin
          OUT_INSTRUCTION = {16'h0000, half_buf_q};
          OUT_COMPRESS    = 1'b1;
          adv_pc          = pc_q + 32'd2;
          adv_valid       = 1'b0;
        end else begin
          OUT_INSTRUCTION = {IMEM_RDATA[15:0], half_buf_q};
          adv_pc          = pc_q + 32'd4;
          adv_buf         = IMEM_RDATA[31:16];
        end
      end
      MISALIGNED: begin
        if (is_rvc(IMEM_RDATA[31:16])) begin
          OUT_INSTRUCTION = {16'h0000, IMEM_RDATA[31:16]};
          OUT_COMPRESS    = 1'b1;
          adv_pc          = pc_q + 32'd2;
        end else begin
          // Upper half starts a 32-bit instruction: stash it and refetch the next word.
          OUT_BUBBLE = 1'b1;
          adv_buf    = IMEM_RDATA[31:16];
          adv_valid  = 1'b1;
        end
      end
      default: begin
        // Corrupted state: emit a bubble and drop the stash so fetch resynchronises.
        OUT_BUBBLE = 1'b1;
        adv_valid  = 1'b0;
      end
    endcase

    OUT_ILLEGAL = !OUT_BUBBLE &&
                  (OUT_COMPRESS ? (OUT_INSTRUCTION[15:0] == 16'h0000)
                                : (OUT_INSTRUCTION == 32'hFFFF_FFFF));
  end

  // Redirect wins over stall; the stash contents are left alone on redirect.
  always_comb begin
    pc_d         = pc_q;
    half_buf_d   = half_buf_q;
    half_valid_d = half_valid_q;
    if (PC_SEL) begin
      pc_d         = {PC_TARGET[31:1], 1'b0};
      half_valid_d = 1'b0;
    end else if (ENA) begin
      pc_d         = adv_pc;
      half_buf_d   = adv_buf;
      half_valid_d = adv_valid;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q         <= RESET_PC;
      half_buf_q   <= 16'h0000;
      half_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      pc_q         <= pc_d;
      half_buf_q   <= half_buf_d;
      half_valid_q <= half_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_align.sv
// Directed self-checking bench for if_fetch_align with a combinational-read memory model.
module tb_if_fetch_align;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENA;
  logic        PC_SEL;
  logic [31:0] PC_TARGET;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic [31:0] OUT_INSTRUCTION;
  logic [31:0] OUT_PC;
  logic        OUT_COMPRESS;
  logic        OUT_ILLEGAL;
  logic        OUT_BUBBLE;

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  if_fetch_align dut (
    .CLK(CLK), .RESET(RESET), .ENA(ENA), .PC_SEL(PC_SEL), .PC_TARGET(PC_TARGET),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .OUT_INSTRUCTION(OUT_INSTRUCTION), .OUT_PC(OUT_PC), .OUT_COMPRESS(OUT_COMPRESS),
    .OUT_ILLEGAL(OUT_ILLEGAL), .OUT_BUBBLE(OUT_BUBBLE)
  );

  always #5 CLK = ~CLK;

  assign IMEM_RDATA = mem[IMEM_ADDR[5:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic c, input logic ill, input logic bub);
    check({tag, "_pc"},    OUT_PC, pc);
    check({tag, "_instr"}, OUT_INSTRUCTION, instr);
    check({tag, "_c"},     {31'd0, OUT_COMPRESS}, {31'd0, c});
    check({tag, "_ill"},   {31'd0, OUT_ILLEGAL}, {31'd0, ill});
    check({tag, "_bub"},   {31'd0, OUT_BUBBLE}, {31'd0, bub});
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic reset_pulse();
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    mem[0]  = 32'h00A0_0513;
    mem[1]  = 32'h4585_4505;
    mem[2]  = 32'h0513_4605;
    mem[3]  = 32'h0001_00B0;
    mem[15] = 32'h0000_0293;
    RESET = 1'b1; ENA = 1'b1; PC_SEL = 1'b0; PC_TARGET = 32'h0;

    // Reset state, memory at 0 presented.
    #1;
    check("rst_addr", IMEM_ADDR, 32'h0);
    check_out("rst", 32'h0, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
    tick();
    RESET = 1'b0;
    #1;

    // Sequential fetch.
    check_out("seq0", 32'h0, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
    tick(); check_out("seq4", 32'h4, 32'h0000_4505, 1'b1, 1'b0, 1'b0);
    tick(); check_out("seq6", 32'h6, 32'h0000_4585, 1'b1, 1'b0, 1'b0);

    // Stall three cycles while buffered at 6.
    ENA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("stall", 32'h6, 32'h0000_4585, 1'b1, 1'b0, 1'b0);
    end
    ENA = 1'b1;
    tick(); check_out("seq8", 32'h8, 32'h0000_4605, 1'b1, 1'b0, 1'b0);
    tick(); check_out("seqA", 32'hA, 32'h00B0_0513, 1'b0, 1'b0, 1'b0);
    check("seqA_addr", IMEM_ADDR, 32'hC);
    tick(); check_out("seqE", 32'hE, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // Redirect to misaligned 32-bit instruction.
    PC_SEL = 1'b1; PC_TARGET = 32'hA;
    tick(); PC_SEL = 1'b0;
    check_out("rdA_bub", 32'hA, 32'h0000_0013, 1'b0, 1'b0, 1'b1);
    check("rdA_addr", IMEM_ADDR, 32'h8);
    tick(); check_out("rdA_1", 32'hA, 32'h00B0_0513, 1'b0, 1'b0, 1'b0);
    tick(); check_out("rdA_2", 32'hE, 32'h0000_0001, 1'b1, 1'b0, 1'b0);

    // Redirect to misaligned compressed instruction.
    PC_SEL = 1'b1; PC_TARGET = 32'h6;
    tick(); PC_SEL = 1'b0;
    check_out("rd6_0", 32'h6, 32'h0000_4585, 1'b1, 1'b0, 1'b0);
    check("rd6_addr", IMEM_ADDR, 32'h4);
    tick(); check_out("rd6_1", 32'h8, 32'h0000_4605, 1'b1, 1'b0, 1'b0);

    // Redirect during stall while buffered at A; odd target bit 0 dropped.
    tick(); check("buf_addr", IMEM_ADDR, 32'hC);
    ENA = 1'b0; PC_SEL = 1'b1; PC_TARGET = 32'h9;
    tick(); PC_SEL = 1'b0;
    check("sim_addr", IMEM_ADDR, 32'h8);
    check_out("sim", 32'h8, 32'h0000_4605, 1'b1, 1'b0, 1'b0);
    tick(); check("sim_hold", OUT_PC, 32'h8);
    ENA = 1'b1;

    // Wrap from FFFF_FFFC to 0.
    PC_SEL = 1'b1; PC_TARGET = 32'hFFFF_FFFC;
    tick(); PC_SEL = 1'b0;
    check_out("wrap0", 32'hFFFF_FFFC, 32'h0000_0293, 1'b0, 1'b0, 1'b0);
    tick(); check_out("wrap1", 32'h0, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);

    // Illegal compressed all-zero halves.
    mem[0] = 32'h0000_0000;
    reset_pulse();
    check_out("ilc0", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick(); check_out("ilc2", 32'h2, 32'h0, 1'b1, 1'b1, 1'b0);

    // Illegal 32-bit all-ones word still advances by 4.
    mem[0] = 32'hFFFF_FFFF;
    reset_pulse();
    check_out("il32", 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    tick(); check_out("il32n", 32'h4, 32'h0000_4505, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle while buffered.
    mem[0] = 32'h00A0_0513;
    reset_pulse();
    tick(); tick();
    check("ar_pre_addr", IMEM_ADDR, 32'h8);
    check("ar_pre_pc", OUT_PC, 32'h6);
    #2;
    RESET = 1'b1;
    #1;
    check("ar_addr", IMEM_ADDR, 32'h0);
    check_out("ar", 32'h0, 32'h00A0_0513, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_align.md
Name: if_fetch_align

Overview:
- Instruction-fetch stage for the RV32IC pipeline. Sits directly upstream of the IF/ID pipeline register and drives its instruction, PC, compress and illegal inputs.
- Holds the architectural fetch PC and reads 32-bit words from an asynchronous-read instruction memory.
- Extracts 16-bit compressed and 32-bit instructions, including 32-bit instructions that straddle a word boundary, using a one-halfword stash buffer.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction emitted while no instruction is available.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENA  input  1  advance enable; 0 = stall, all state held.
- PC_SEL  input  1  redirect request (branch, jump or trap taken).
- PC_TARGET  input  32  redirect target; bit 0 ignored (treated as 0).
- IMEM_ADDR  output  32  word address to instruction memory; bits [1:0] always 2'b00.
- IMEM_RDATA  input  32  word at IMEM_ADDR, valid in the same cycle (combinational read).
- OUT_INSTRUCTION  output  32  instruction to IF/ID; compressed instructions are zero-extended ({16'h0, half}).
- OUT_PC  output  32  address of OUT_INSTRUCTION.
- OUT_COMPRESS  output  1  1 = OUT_INSTRUCTION is a 16-bit instruction.
- OUT_ILLEGAL  output  1  1 = instruction is illegal: compressed 16'h0000, or 32-bit 32'hFFFF_FFFF.
- OUT_BUBBLE  output  1  1 = OUT_INSTRUCTION is NOP_INSTR, not a fetched instruction.

Behaviour:
- State registers:
  - PC (32).
  - HALF_BUF (16): upper halfword of the last word read.
  - HALF_VALID (1).
- Invariant: HALF_VALID=1 implies PC[1]=1 and HALF_BUF holds the halfword at PC.
- Outputs are combinational from state and IMEM_RDATA. State updates on the rising CLK edge.
- Reset (asynchronous): PC=RESET_PC, HALF_BUF=0, HALF_VALID=0. Outputs then follow state; with RESET_PC=0, OUT_PC=0 and memory at 0 is presented.
- Compressed test: a halfword is compressed iff bits [1:0] != 2'b11.
- IMEM_ADDR:
  - {PC[31:2],2'b00} when HALF_VALID=0.
  - {PC[31:2],2'b00}+4 when HALF_VALID=1.
- Three states, derived from {HALF_VALID, PC[1]}:
  - ALIGNED (0,0):
    - Word = IMEM_RDATA.
    - Low half compressed: emit it, COMPRESS=1, next PC+=2, HALF_BUF=word[31:16], HALF_VALID=1 (→ BUFFERED).
    - Otherwise: emit word, COMPRESS=0, next PC+=4 (stay ALIGNED).
  - BUFFERED (1,1):
    - HALF_BUF compressed: emit it, COMPRESS=1, next PC+=2, HALF_VALID=0 (→ ALIGNED). IMEM_RDATA is ignored.
    - Otherwise: emit {IMEM_RDATA[15:0], HALF_BUF}, COMPRESS=0, next PC+=4, HALF_BUF=IMEM_RDATA[31:16], HALF_VALID stays 1.
  - MISALIGNED (0,1), reached only by redirect to a PC with bit 1 set:
    - Upper half compressed: emit it, COMPRESS=1, next PC+=2 (→ ALIGNED).
    - Otherwise: emit bubble (NOP_INSTR, COMPRESS=0, ILLEGAL=0, BUBBLE=1, OUT_PC=PC), PC held, HALF_BUF=IMEM_RDATA[31:16], HALF_VALID=1 (→ BUFFERED).
- BUBBLE=0 in every case except the MISALIGNED 32-bit case.
- ENA=0 with PC_SEL=0: all state held; outputs remain valid and unchanged for stable IMEM_RDATA.
- PC_SEL=1 (priority over ENA, applied regardless of ENA): PC={PC_TARGET[31:1],1'b0}, HALF_VALID=0, HALF_BUF unchanged. The current cycle's output is discarded by the flushed IF/ID register.
- RESET mid-operation: immediate return to reset state, any buffered half is dropped.
- PC arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is permitted and not flagged.
- OUT_ILLEGAL does not alter sequencing; the instruction is still emitted and PC still advances.

Test Plan:
- Memory image: mem[0]=32'h00A0_0513, mem[4]=32'h4585_4505, mem[8]=32'h0513_4605, mem[C]=32'h0001_00B0.
  - Reset, ENA=1 → (PC, instr, C) per cycle: (0, 00A00513, 0), (4, 00004505, 1), (6, 00004585, 1), (8, 00004605, 1), (A, 00B00513, 0), (E, 00000001, 1).
  - Check IMEM_ADDR=0xC during the PC=0xA cycle.
- Stall: ENA=0 for 3 cycles while at PC=6 → outputs held at (6, 00004585, 1), no PC change; resume yields PC=8.
- Redirect to misaligned 32-bit: PC_SEL=1, PC_TARGET=0xA → cycle 1 BUBBLE=1, instr=00000013, PC=A; cycle 2 (A, 00B00513, 0); cycle 3 (E, 00000001, 1).
- Redirect to misaligned compressed: target 0x6 → first output (6, 00004585, 1), no bubble; next PC=8.
- Simultaneous PC_SEL=1 and ENA=0 while BUFFERED → PC=target, HALF_VALID=0 after the edge.
- Illegal and reset:
  - Word 32'h0000_0000 at PC 0 → (0, 00000000, C=1, ILLEGAL=1), next PC=2.
  - RESET asserted asynchronously mid-cycle while BUFFERED → PC=RESET_PC and HALF_VALID=0 immediately, without waiting for a clock edge.
